// File: rtl/des_frame_rx.sv
// Frame receiver for the DES controller: one command byte followed by eight
// payload bytes, with an inter-byte timeout and overrun/bad-command reporting.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a command byte
// GET_DATA | collecting the 8 payload bytes, inter-byte timer running
// HOLD     | complete frame presented until the DES controller accepts it
module des_frame_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_fRxDone,
  input  logic [7:0]  i_RxData,
  input  logic        i_fReady,
  output logic        o_fValid,
  output logic [1:0]  o_Cmd,
  output logic [63:0] o_Data,
  output logic        o_fErr,
  output logic [1:0]  o_ErrCode,
  output logic        o_fBusy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_DATA = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [63:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      IDLE: begin
        if (i_fRxDone) begin
          if (i_RxData[7:2] == 6'd0) begin
            cmd_d   = i_RxData[1:0];
            cnt_d   = '0;
            timer_d = '0;
            data_d  = '0;
            state_d = GET_DATA;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CMD;
          end
        end
      end

      GET_DATA: begin
        // A strobe on the terminal timer cycle still counts as in time.
        if (i_fRxDone) begin
          data_d  = {data_q[55:0], i_RxData};
          cnt_d   = cnt_q + 3'd1;
          timer_d = '0;
          if (cnt_q == 3'd7) begin
            state_d = HOLD;
          end
        end else if (timer_q == TIMER_MAX) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          cnt_d      = '0;
          timer_d    = '0;
          data_d     = '0;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      HOLD: begin
        if (i_fRxDone) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (i_fReady) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_fValid  = (state_q == HOLD);
  assign o_fBusy   = (state_q != IDLE);
  assign o_Cmd     = cmd_q;
  assign o_Data    = data_q;
  assign o_fErr    = err_q;
  assign o_ErrCode = err_code_q;

endmodule

// File: tb/tb_des_frame_rx.sv
// Directed bench for des_frame_rx: a table of command/frame vectors plus
// hand-written sequences for timeout, overrun and mid-frame reset.
module tb_des_frame_rx;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        ready;
  logic        valid;
  logic [1:0]  cmd;
  logic [63:0] data;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  int n_checks;
  int n_pass;

  des_frame_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_fRxDone (rx_done),
    .i_RxData  (rx_data),
    .i_fReady  (ready),
    .o_fValid  (valid),
    .o_Cmd     (cmd),
    .o_Data    (data),
    .o_fErr    (err),
    .o_ErrCode (err_code),
    .o_fBusy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        bad;
    logic [7:0]  cmd_byte;
    logic [63:0] payload;
    logic [1:0]  exp_cmd;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called just after a falling edge; returns just after the next falling edge,
  // so the rising edge in between has sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [63:0] p);
    send_byte(c);
    for (int i = 0; i < 8; i++) send_byte(p[63-8*i -: 8]);
  endtask

  initial begin
    int   seen;
    logic err_seen;

    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    ready    = 1'b0;

    //           bad   cmd    payload                exp_cmd exp_data
    vecs[0] = '{1'b0, 8'h02, 64'h1122334455667788, 2'd2, 64'h1122334455667788};
    vecs[1] = '{1'b1, 8'h41, 64'h0,                2'd0, 64'h0};
    vecs[2] = '{1'b0, 8'h00, 64'h0123456789ABCDEF, 2'd0, 64'h0123456789ABCDEF};
    vecs[3] = '{1'b1, 8'hFC, 64'h0,                2'd0, 64'h0};
    vecs[4] = '{1'b0, 8'h01, 64'hFFFFFFFFFFFFFFFF, 2'd1, 64'hFFFFFFFFFFFFFFFF};
    vecs[5] = '{1'b1, 8'h80, 64'h0,                2'd0, 64'h0};
    vecs[6] = '{1'b0, 8'h03, 64'h0,                2'd3, 64'h0};

    // Reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_data", data, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_code", 64'(err_code), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table: ready held high, so each good frame is valid for exactly one cycle.
    ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].bad) begin
        send_byte(vecs[v].cmd_byte);
        check($sformatf("v%0d_bad_err", v), 64'(err), 64'd1);
        check($sformatf("v%0d_bad_code", v), 64'(err_code), 64'd1);
        check($sformatf("v%0d_bad_busy", v), 64'(busy), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_bad_err_drop", v), 64'(err), 64'd0);
      end else begin
        send_frame(vecs[v].cmd_byte, vecs[v].payload);
        check($sformatf("v%0d_valid", v), 64'(valid), 64'd1);
        check($sformatf("v%0d_cmd", v), 64'(cmd), 64'(vecs[v].exp_cmd));
        check($sformatf("v%0d_data", v), data, vecs[v].exp_data);
        check($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
        @(negedge clk);
        check($sformatf("v%0d_valid_drop", v), 64'(valid), 64'd0);
        check($sformatf("v%0d_busy_drop", v), 64'(busy), 64'd0);
      end
    end

    // Timeout: timer is 0 in the first idle cycle, hits 15 in idle cycle 15
    // (0-based); the error is registered on the 16th idle rising edge.
    ready = 1'b0;
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    seen = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (err && seen < 0) seen = j;
    end
    check("to_edge", 64'(seen), 64'd16);
    check("to_code", 64'(err_code), 64'd2);
    check("to_busy", 64'(busy), 64'd0);
    check("to_valid", 64'(valid), 64'd0);

    // Byte arriving on the terminal timer cycle is accepted.
    ready = 1'b1;
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    err_seen = 1'b0;
    for (int j = 1; j <= TO - 1; j++) begin
      @(negedge clk);
      if (err) err_seen = 1'b1;
    end
    send_byte(8'hEE);
    if (err) err_seen = 1'b1;
    check("edge_busy", 64'(busy), 64'd1);
    send_byte(8'hF0);
    send_byte(8'hF1);
    send_byte(8'hF2);
    check("edge_no_err", 64'(err_seen), 64'd0);
    check("edge_valid", 64'(valid), 64'd1);
    check("edge_data", data, 64'hAABBCCDDEEF0F1F2);
    @(negedge clk);

    // Overrun while holding a frame that is not yet accepted.
    ready = 1'b0;
    send_frame(8'h01, 64'h0102030405060708);
    @(negedge clk);
    @(negedge clk);
    check("hold_valid", 64'(valid), 64'd1);
    send_byte(8'h99);
    check("ovr_err", 64'(err), 64'd1);
    check("ovr_code", 64'(err_code), 64'd3);
    check("ovr_data", data, 64'h0102030405060708);
    check("ovr_cmd", 64'(cmd), 64'd1);
    check("ovr_valid", 64'(valid), 64'd1);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", 64'(valid), 64'd0);

    // Accept and overrun on the same edge; the byte must not start a frame.
    ready = 1'b0;
    send_frame(8'h02, 64'h8877665544332211);
    ready = 1'b1;
    send_byte(8'h00);
    check("both_err", 64'(err), 64'd1);
    check("both_code", 64'(err_code), 64'd3);
    check("both_valid", 64'(valid), 64'd0);
    check("both_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // Reset after the 5th payload byte clears everything without an error.
    send_byte(8'h02);
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", 64'(valid), 64'd0);
    check("mrst_cmd", 64'(cmd), 64'd0);
    check("mrst_data", data, 64'd0);
    check("mrst_err", 64'(err), 64'd0);
    check("mrst_code", 64'(err_code), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_err_after", 64'(err), 64'd0);
    send_frame(8'h02, 64'hCAFEBABE12345678);
    check("mrst_frame_valid", 64'(valid), 64'd1);
    check("mrst_frame_cmd", 64'(cmd), 64'd2);
    check("mrst_frame_data", data, 64'hCAFEBABE12345678);
    @(negedge clk);
    check("mrst_frame_drop", 64'(valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
